// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller feeding uart_tx through its avail/active/done handshake.
// The host pushes at clock rate; bytes are handed to uart_tx one at a time in strict order.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_avail,
  input  logic              i_tx_active,
  input  logic              i_tx_done
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              pop;
  logic              push;

  // Launch sequencing; the pop happens on the IDLE -> LAUNCH transition.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!o_empty && !i_tx_active) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (i_tx_active) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is kept then.
  assign push = i_wr_en && (!o_full || pop);

  always_comb begin
    count_nxt = o_count;
    case ({push, pop})
      2'b10:   count_nxt = o_count + 1'b1;
      2'b01:   count_nxt = o_count - 1'b1;
      default: count_nxt = o_count;
    endcase
  end

  assign o_tx_avail = (state == LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
      o_tx_byte  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_tx_byte <= mem[rd_ptr];
      end
      o_count    <= count_nxt;
      o_full     <= (count_nxt == (ADDR_W+1)'(DEPTH));
      o_empty    <= (count_nxt == '0);
      o_overflow <= i_wr_en && !push;
    end
  end

endmodule
